// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory path and the responder.
// The core side is the master; the responder is the slave.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder: one request at a time, WAIT_CYCLES wait states,
// byte/half/word loads and stores with extension and access checking.
module mem_responder_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  mem_responder_if.slave bus
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, nxt;
  logic [3:0]  cnt;
  logic        q_we;
  logic [2:0]  q_f3;
  logic [31:0] q_addr, q_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, commit;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  off;
  logic [3:0]  lane_mask, lane_we;
  logic        illegal, misal, oob, err;
  logic [31:0] wr_data, rd_word, load_data;
  logic [15:0] rd_shift;

  assign accept = bus.req_valid && (state == S_IDLE);

  // With zero wait states the commit edge is the accept edge, so decode the live request.
  assign cur_we    = (state == S_IDLE) ? bus.req_we     : q_we;
  assign cur_f3    = (state == S_IDLE) ? bus.req_funct3 : q_f3;
  assign cur_addr  = (state == S_IDLE) ? bus.req_addr   : q_addr;
  assign cur_wdata = (state == S_IDLE) ? bus.req_wdata  : q_wdata;

  assign commit = resetn && ((accept && (WAIT_CYCLES == 0)) ||
                             ((state == S_WAIT) && (cnt == 4'd0)));

  // FSM: state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;

  // FSM: next state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.req_valid) nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0)   nxt = S_RESP;
      S_RESP: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready  = resetn && (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt     <= '0;
      q_we    <= 1'b0;
      q_f3    <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
    end else if (accept) begin
      cnt     <= CNT_INIT;
      q_we    <= bus.req_we;
      q_f3    <= bus.req_funct3;
      q_addr  <= bus.req_addr;
      q_wdata <= bus.req_wdata;
    end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= load_data;
      err_q   <= err;
    end

  assign off = cur_addr[1:0];

  always_comb begin
    illegal   = 1'b0;
    misal     = 1'b0;
    lane_mask = 4'b0000;
    case (cur_f3)
      3'b000, 3'b100: lane_mask = 4'b0001;
      3'b001, 3'b101: begin lane_mask = 4'b0011; misal = off[0]; end
      3'b010:         begin lane_mask = 4'b1111; misal = |off;   end
      default:        illegal = 1'b1;
    endcase
    if (cur_we && cur_f3[2]) illegal = 1'b1;
  end

  // No aliasing: any address bit above the RAM is a rejected access.
  assign oob     = |cur_addr[31:ADDR_WIDTH+2];
  assign err     = illegal | misal | oob;
  assign lane_we = lane_mask << off;
  assign wr_data = cur_wdata << {off, 3'b000};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mem_responder_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (commit && cur_we && !err && lane_we[l]),
      .idx   (cur_addr[ADDR_WIDTH+1:2]),
      .wdata (wr_data[8*l +: 8]),
      .rdata (rd_word[8*l +: 8])
    );
  end

  assign rd_shift = 16'(rd_word >> {off, 3'b000});

  always_comb begin
    case (cur_f3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'b0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift};
      3'b101:  load_data = {16'b0, rd_shift};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase
    if (cur_we || err) load_data = '0;
  end
endmodule
